// File: rtl/shift_seq_ctrl.sv
// Purpose    : stage-per-cycle shift sequencer (sll/sra/srl by 1/2/4/8/16) in place of a full barrel shifter.
// Latency    : popcount(shamt)+1 cycles from accept to result_valid (1 for shamt=0 or op=11), so 1..6.
// Backpressure: result is held in DONE until result_ready; start_ready stays low from accept to handshake.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   start/start_ready   request handshake; op, data_in, shamt are latched on accept
//   result/result_valid/result_ready  result handshake; result holds its value afterwards
//   busy                high while an operation is in flight (SHIFT or DONE)
//   stage_cnt           stages applied for the current/last operation
module shift_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               start_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic [2:0]         stage_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         op_r;

  // One-hot of the highest set bit of rem. Numerically this is 2^k, which
  // is exactly the distance of the stage applied this cycle.
  logic [SHAMT_W-1:0] stage_amt;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   acc_next;

  always_comb begin
    stage_amt = '0;
    // Ascending scan: the last hit wins, leaving the most significant bit.
    for (int i = 0; i < SHAMT_W; i++) begin
      if (rem[i]) begin
        stage_amt    = '0;
        stage_amt[i] = 1'b1;
      end
    end
    rem_next = rem & ~stage_amt;
  end

  always_comb begin
    acc_next = acc;
    case (op_r)
      OP_SLL:  acc_next = acc << stage_amt;
      OP_SRA:  acc_next = $unsigned($signed(acc) >>> stage_amt);
      OP_SRL:  acc_next = acc >> stage_amt;
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      acc          <= '0;
      rem          <= '0;
      op_r         <= '0;
      stage_cnt    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      start_ready  <= 1'b1;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc         <= data_in;
            rem         <= shamt;
            op_r        <= op;
            stage_cnt   <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            // Nothing to shift: present the operand directly next cycle.
            if (shamt == '0 || op == OP_PASS) begin
              state        <= S_DONE;
              result       <= data_in;
              result_valid <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          acc       <= acc_next;
          rem       <= rem_next;
          stage_cnt <= stage_cnt + 3'd1;
          if (rem_next == '0) begin
            state        <= S_DONE;
            result       <= acc_next;
            result_valid <= 1'b1;
          end
        end

        S_DONE: begin
          if (result_ready) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Purpose    : scoreboard bench for shift_seq_ctrl against a single-shift reference model.
// Latency    : expects result_valid popcount(shamt)+1 cycles after accept (1 for op=11 or shamt=0).
// Backpressure: drives result_ready low/random while valid and spams start while busy.
module tb_shift_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;
  logic [2:0]  stage_cnt;

  shift_seq_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_ready (start_ready),
    .op          (op),
    .data_in     (data_in),
    .shamt       (shamt),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy),
    .stage_cnt   (stage_cnt)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  stg;
    int unsigned t_acc;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: one shift by the full amount, with sra built from srl plus sign fill.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    case (o)
      2'b00:   return d << s;
      2'b01:   return (d >> s) | (d[31] ? ~(ones >> s) : 32'h0);
      2'b10:   return d >> s;
      default: return d;
    endcase
  endfunction

  // Monitor: compares each newly presented result against the scoreboard.
  logic        prev_valid = 1'b0;
  logic [31:0] held = '0;
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && result_valid) begin
      if (!prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%08h, expected no result outstanding", result);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("stage_cnt", {29'b0, stage_cnt}, {29'b0, e.stg});
          check("latency", cyc - e.t_acc, e.lat);
        end
        held = result;
      end else begin
        check("result_stable", result, held);
      end
      check("busy_in_done", {31'b0, busy}, 32'd1);
      check("start_ready_in_done", {31'b0, start_ready}, 32'd0);
    end
    prev_valid = result_valid;
  end

  // Issue one request (called at a negedge with the DUT idle) and see it through.
  task automatic run_req(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input int hold, input bit spam, input bit rand_ready);
    exp_t e;
    int   budget;
    bit   done;
    check("start_ready_idle", {31'b0, start_ready}, 32'd1);
    op      = o;
    data_in = d;
    shamt   = s;
    start   = 1'b1;
    e.res   = ref_shift(o, d, s);
    e.stg   = (o == 2'b11) ? 3'd0 : 3'($countones(s));
    e.t_acc = cyc;
    e.lat   = (o == 2'b11) ? 1 : $countones(s) + 1;
    sb.push_back(e);
    @(negedge clock);
    start   = 1'b0;
    op      = 2'($urandom);
    data_in = $urandom;
    shamt   = 5'($urandom);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    budget = 40;
    done   = 1'b0;
    while (!done && budget > 0) begin
      if (hold > 0) begin
        result_ready = 1'b0;
        if (result_valid) hold--;
      end else begin
        result_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (spam) begin
        start   = 1'($urandom_range(0, 1));
        op      = 2'($urandom);
        data_in = $urandom;
        shamt   = 5'($urandom);
      end
      if (result_valid && result_ready) done = 1'b1;
      @(negedge clock);
      budget--;
    end
    start        = 1'b0;
    result_ready = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got no result in 40 cycles, expected 0x%08h", e.res);
      sb.delete();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
    end else begin
      check("start_ready_after_hs", {31'b0, start_ready}, 32'd1);
      check("valid_after_hs", {31'b0, result_valid}, 32'd0);
      check("busy_after_hs", {31'b0, busy}, 32'd0);
      check("result_hold_idle", result, e.res);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_start_ready", {31'b0, start_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_stage_cnt", {29'b0, stage_cnt}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Directed cases
    run_req(2'b01, 32'h8000_0000, 5'd8,  0, 1'b0, 1'b0);
    run_req(2'b10, 32'h8000_0000, 5'd31, 0, 1'b0, 1'b0);
    run_req(2'b01, 32'h8000_0000, 5'd31, 0, 1'b0, 1'b0);
    run_req(2'b00, 32'h0000_0001, 5'd0,  0, 1'b0, 1'b0);
    run_req(2'b11, 32'h1234_5678, 5'd7,  0, 1'b0, 1'b0);
    run_req(2'b00, 32'h0000_000F, 5'd4,  5, 1'b1, 1'b0);

    // Reset in the second SHIFT cycle drops the operation entirely.
    op      = 2'b01;
    data_in = 32'hF000_0000;
    shamt   = 5'd21;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_start_ready", {31'b0, start_ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, result_valid}, 32'd0);
    check("midrst_result", result, 32'h0);
    check("midrst_stage_cnt", {29'b0, stage_cnt}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    run_req(2'b10, 32'h0000_0100, 5'd4, 0, 1'b0, 1'b0);

    // Random traffic with random backpressure and busy-time start pulses.
    for (int i = 0; i < 1000; i++) begin
      run_req(2'($urandom), $urandom, 5'($urandom), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
